rhd_miso_deserializer: RTL and testbench

Controller-side receive stage for the 16-probe RHD headstage interface. Consumes the MISO1/MISO2 pairs returned by every probe during each CS-low SPI frame and deserializes them into parallel 16-bit words per probe and line, using the same CS and SCLK that drive the headstages. It compensates for cable round-trip delay with a programmable sample delay. It flags malformed frames (bit count other than 16) and feeds the downstream sample-packing/FIFO logic.

---
 rtl/rhd_miso_deserializer.sv | 164 ++++++++++++++++
 tb/tb_rhd_miso_deserializer.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/rhd_miso_deserializer.sv
// rhd_miso_deserializer
// Receive stage for the RHD headstage SPI link. Turns the MISO1/MISO2 bit
// streams returned by every probe during a CS-low frame into parallel 16-bit
// words. Frames with a bit count other than 16 are flagged and counted.
// SCLK sampling is pushed back by CABLE_DELAY clocks to cover the cable
// round trip.

module rhd_miso_deserializer #(
    parameter int NUM_PROBES  = 16,
    parameter int CABLE_DELAY = 0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       CS,
    input  logic                       SCLK,
    input  logic [NUM_PROBES-1:0]      MISO1,
    input  logic [NUM_PROBES-1:0]      MISO2,
    output logic [16*NUM_PROBES-1:0]   data1,
    output logic [16*NUM_PROBES-1:0]   data2,
    output logic                       data_valid,
    output logic                       frame_error,
    output logic [7:0]                 error_count
);

    localparam logic [1:0] WAIT_IDLE = 2'd0;
    localparam logic [1:0] IDLE      = 2'd1;
    localparam logic [1:0] SHIFT     = 2'd2;

    logic                  cs_r;
    logic                  sclk_r;
    logic [NUM_PROBES-1:0] miso1_r;
    logic [NUM_PROBES-1:0] miso2_r;
    logic                  cs_d;
    logic                  sclk_d;

    logic                  sclk_rise_e;
    logic                  cs_rise_e;
    logic                  cs_fall_e;

    logic                  strobe;
    logic                  cs_rise_dly;

    logic [1:0]            state;
    logic [4:0]            bit_count;
    logic [NUM_PROBES-1:0][15:0] shift1;
    logic [NUM_PROBES-1:0][15:0] shift2;

    // Register the pins once, and keep a second copy of CS/SCLK for edge detection.
    always_ff @(posedge clk) begin
        // NOTE: every clocked register uses <= so all flops update from pre-edge values.
        if (rst) begin
            cs_r    <= 1'b0;
            sclk_r  <= 1'b0;
            miso1_r <= '0;
            miso2_r <= '0;
            cs_d    <= 1'b0;
            sclk_d  <= 1'b0;
        end else begin
            cs_r    <= CS;
            sclk_r  <= SCLK;
            miso1_r <= MISO1;
            miso2_r <= MISO2;
            cs_d    <= cs_r;
            sclk_d  <= sclk_r;
        end
    end

    // Registered edge events; SCLK rises only count while CS is low.
    always_ff @(posedge clk) begin
        if (rst) begin
            sclk_rise_e <= 1'b0;
            cs_rise_e   <= 1'b0;
            cs_fall_e   <= 1'b0;
        end else begin
            sclk_rise_e <= sclk_r & ~sclk_d & ~cs_r;
            cs_rise_e   <= cs_r & ~cs_d;
            cs_fall_e   <= ~cs_r & cs_d;
        end
    end

    // Cable-delay pipeline: strobe and frame end travel together so the last
    // bit is always shifted in before the frame is judged.
    generate
        if (CABLE_DELAY == 0) begin : g_no_delay
            assign strobe      = sclk_rise_e;
            assign cs_rise_dly = cs_rise_e;
        end else begin : g_delay
            logic [CABLE_DELAY-1:0] strobe_pipe;
            logic [CABLE_DELAY-1:0] rise_pipe;

            // Shift both events one stage per clock.
            always_ff @(posedge clk) begin
                if (rst) begin
                    strobe_pipe <= '0;
                    rise_pipe   <= '0;
                end else begin
                    strobe_pipe[0] <= sclk_rise_e;
                    rise_pipe[0]   <= cs_rise_e;
                    for (int i = 1; i < CABLE_DELAY; i++) begin
                        strobe_pipe[i] <= strobe_pipe[i-1];
                        rise_pipe[i]   <= rise_pipe[i-1];
                    end
                end
            end

            assign strobe      = strobe_pipe[CABLE_DELAY-1];
            assign cs_rise_dly = rise_pipe[CABLE_DELAY-1];
        end
    endgenerate

    // Frame FSM, shift registers, bit counter and the registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= WAIT_IDLE;
            bit_count   <= '0;
            // NOTE: the shift registers are plain flops (not RAM), so clearing them costs nothing and keeps reset state deterministic.
            shift1      <= '0;
            shift2      <= '0;
            data1       <= '0;
            data2       <= '0;
            data_valid  <= 1'b0;
            frame_error <= 1'b0;
            error_count <= '0;
        end else begin
            data_valid  <= 1'b0;
            frame_error <= 1'b0;
            case (state)
                WAIT_IDLE: begin
                    // A frame in progress at reset release is dropped.
                    if (cs_r) state <= IDLE;
                end
                IDLE: begin
                    if (cs_fall_e) begin
                        bit_count <= '0;
                        state     <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (strobe) begin
                        for (int p = 0; p < NUM_PROBES; p++) begin
                            shift1[p] <= {shift1[p][14:0], miso1_r[p]};
                            shift2[p] <= {shift2[p][14:0], miso2_r[p]};
                        end
                        if (bit_count != 5'd17) bit_count <= bit_count + 5'd1;
                    end
                    // A stray CS fall here is ignored; only the delayed rise ends the frame.
                    if (cs_rise_dly) begin
                        state <= IDLE;
                        if (bit_count == 5'd16) begin
                            data1      <= shift1;
                            data2      <= shift2;
                            data_valid <= 1'b1;
                        end else begin
                            frame_error <= 1'b1;
                            if (error_count != 8'hFF) error_count <= error_count + 8'd1;
                        end
                    end
                end
                default: state <= WAIT_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rhd_miso_deserializer.sv
// Directed bench for rhd_miso_deserializer. Two instances share stimulus:
// one with no cable delay and one with a three-cycle cable delay.

module tb_rhd_miso_deserializer;

    logic        clk = 1'b0;
    logic        rst;
    logic        CS;
    logic        SCLK;
    logic [15:0] MISO1;
    logic [15:0] MISO2;

    logic [255:0] data1_0, data2_0, data1_3, data2_3;
    logic         dv0, fe0, dv3, fe3;
    logic [7:0]   ec0, ec3;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int rise_cyc = 0;
    int dv0_cnt = 0, fe0_cnt = 0, dv3_cnt = 0, fe3_cnt = 0, both_cnt = 0;
    int dv0_cyc = 0, dv3_cyc = 0;
    int dv0_base, fe0_base, dv3_base, fe3_base;

    logic [15:0] m1 [16];
    logic [15:0] m2 [16];

    rhd_miso_deserializer #(.NUM_PROBES(16), .CABLE_DELAY(0)) dut0 (
        .clk(clk), .rst(rst), .CS(CS), .SCLK(SCLK), .MISO1(MISO1), .MISO2(MISO2),
        .data1(data1_0), .data2(data2_0), .data_valid(dv0), .frame_error(fe0),
        .error_count(ec0)
    );

    rhd_miso_deserializer #(.NUM_PROBES(16), .CABLE_DELAY(3)) dut3 (
        .clk(clk), .rst(rst), .CS(CS), .SCLK(SCLK), .MISO1(MISO1), .MISO2(MISO2),
        .data1(data1_3), .data2(data2_3), .data_valid(dv3), .frame_error(fe3),
        .error_count(ec3)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Pulse bookkeeping, sampled on the falling edge.
    always @(negedge clk) begin
        if (dv0) begin dv0_cnt++; dv0_cyc = cyc; end
        if (dv3) begin dv3_cnt++; dv3_cyc = cyc; end
        if (fe0) fe0_cnt++;
        if (fe3) fe3_cnt++;
        if ((dv0 && fe0) || (dv3 && fe3)) both_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_miso(input int b);
        for (int i = 0; i < 16; i++) begin
            MISO1[i] = (b < 16) ? m1[i][15-b] : 1'b0;
            MISO2[i] = (b < 16) ? m2[i][15-b] : 1'b0;
        end
    endtask

    task automatic begin_frame();
        CS = 1'b0;
        tick();
        tick();
    endtask

    // One SCLK period: 2 clocks high, 2 low; MISO changes `lag` clocks after the rise.
    task automatic pulse(input int b, input int lag);
        SCLK = 1'b1;
        if (lag == 0) set_miso(b);
        for (int c = 1; c <= 4; c++) begin
            tick();
            if (c == 2) SCLK = 1'b0;
            if (c == lag) set_miso(b);
        end
    endtask

    task automatic end_frame(input int gap);
        CS = 1'b1;
        rise_cyc = cyc;
        repeat (gap) tick();
        MISO1 = '0;
        MISO2 = '0;
    endtask

    task automatic frame(input int nbits, input int lag, input int gap);
        begin_frame();
        for (int b = 0; b < nbits; b++) pulse(b, lag);
        end_frame(gap);
    endtask

    task automatic snap();
        dv0_base = dv0_cnt; fe0_base = fe0_cnt;
        dv3_base = dv3_cnt; fe3_base = fe3_cnt;
    endtask

    task automatic clear_words();
        for (int i = 0; i < 16; i++) begin
            m1[i] = 16'h0000;
            m2[i] = 16'h0000;
        end
    endtask

    initial begin
        rst = 1'b1; CS = 1'b1; SCLK = 1'b0; MISO1 = '0; MISO2 = '0;
        clear_words();
        repeat (5) tick();

        // Reset state
        chk("rst_data1", {31'd0, |data1_0}, 32'd0);
        chk("rst_data2", {31'd0, |data2_0}, 32'd0);
        chk("rst_dv", {31'd0, dv0}, 32'd0);
        chk("rst_fe", {31'd0, fe0}, 32'd0);
        chk("rst_ec", {24'd0, ec0}, 32'd0);
        rst = 1'b0;
        repeat (5) tick();

        // Normal 16-bit frame, no lag
        m1[0] = 16'hA5C3; m2[0] = 16'h5A3C;
        m1[15] = 16'h0001; m2[15] = 16'hFFFE;
        snap();
        frame(16, 0, 10);
        chk("norm_d1_A", {16'd0, data1_0[15:0]}, 32'h0000A5C3);
        chk("norm_d2_A", {16'd0, data2_0[15:0]}, 32'h00005A3C);
        chk("norm_d1_P", {16'd0, data1_0[255:240]}, 32'h00000001);
        chk("norm_d2_P", {16'd0, data2_0[255:240]}, 32'h0000FFFE);
        chk("norm_d1_B", {16'd0, data1_0[31:16]}, 32'h00000000);
        chk("norm_dv_cnt", dv0_cnt - dv0_base, 32'd1);
        chk("norm_fe_cnt", fe0_cnt - fe0_base, 32'd0);
        chk("norm_latency", dv0_cyc - rise_cyc, 32'd3);

        // Same words, MISO lagging SCLK by 3 clocks
        snap();
        frame(16, 3, 10);
        chk("cd3_d1_A", {16'd0, data1_3[15:0]}, 32'h0000A5C3);
        chk("cd3_d2_A", {16'd0, data2_3[15:0]}, 32'h00005A3C);
        chk("cd3_d1_P", {16'd0, data1_3[255:240]}, 32'h00000001);
        chk("cd3_dv_cnt", dv3_cnt - dv3_base, 32'd1);
        chk("cd3_latency", dv3_cyc - rise_cyc, 32'd6);
        chk("cd0_corrupt_d1", {16'd0, data1_0[15:0]}, 32'h000052E1);
        chk("cd0_corrupt_d2", {16'd0, data2_0[15:0]}, 32'h00002D1E);

        // Short and long frames: errors counted, data held
        clear_words();
        m1[0] = 16'h1111; m2[0] = 16'h2222;
        snap();
        frame(15, 0, 10);
        chk("short_fe_cnt", fe0_cnt - fe0_base, 32'd1);
        chk("short_ec", {24'd0, ec0}, 32'd1);
        chk("short_hold_d1", {16'd0, data1_0[15:0]}, 32'h000052E1);
        snap();
        frame(17, 0, 10);
        chk("long_fe_cnt", fe0_cnt - fe0_base, 32'd1);
        chk("long_dv_cnt", dv0_cnt - dv0_base, 32'd0);
        chk("long_ec", {24'd0, ec0}, 32'd2);
        chk("long_hold_d2", {16'd0, data2_0[15:0]}, 32'h00002D1E);
        chk("long_ec_cd3", {24'd0, ec3}, 32'd2);

        // Error counter saturation
        snap();
        for (int n = 0; n < 260; n++) frame(15, 0, 8);
        chk("sat_fe_cnt", fe0_cnt - fe0_base, 32'd260);
        chk("sat_ec", {24'd0, ec0}, 32'd255);
        chk("sat_ec_cd3", {24'd0, ec3}, 32'd255);
        chk("sat_dv_cnt", dv0_cnt - dv0_base, 32'd0);

        // Reset in the middle of a frame, released with CS still low
        clear_words();
        m1[0] = 16'hA5C3; m2[0] = 16'h5A3C;
        snap();
        begin_frame();
        for (int b = 0; b < 8; b++) pulse(b, 0);
        rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        for (int b = 8; b < 16; b++) pulse(b, 0);
        end_frame(10);
        chk("mid_rst_dv_cnt", dv0_cnt - dv0_base, 32'd0);
        chk("mid_rst_fe_cnt", fe0_cnt - fe0_base, 32'd0);
        chk("mid_rst_data1", {31'd0, |data1_0}, 32'd0);
        chk("mid_rst_ec", {24'd0, ec0}, 32'd0);
        snap();
        frame(16, 0, 10);
        chk("post_rst_dv_cnt", dv0_cnt - dv0_base, 32'd1);
        chk("post_rst_d1_A", {16'd0, data1_0[15:0]}, 32'h0000A5C3);

        // Back-to-back frames at the minimum CS-high gap (no cable delay)
        snap();
        for (int n = 0; n < 4; n++) begin
            m1[0] = (n % 2 == 0) ? 16'h1234 : 16'hFEDC;
            m2[0] = ~m1[0];
            frame(16, 0, 4);
            chk("b2b_d1_A", {16'd0, data1_0[15:0]}, {16'd0, m1[0]});
            chk("b2b_d2_A", {16'd0, data2_0[15:0]}, {16'd0, m2[0]});
        end
        repeat (6) tick();
        chk("b2b_dv_cnt", dv0_cnt - dv0_base, 32'd4);
        chk("b2b_fe_cnt", fe0_cnt - fe0_base, 32'd0);
        chk("dv_fe_exclusive", both_cnt, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
